// File: rtl/agc_meas_engine.sv
// agc_meas_engine: windowed per-channel power and threshold-crossing accumulator with snapshot readout.
// Optional AGC_MEAS_SAT_EN: square accumulators clamp at full scale and raise sticky sat_o flags.
module agc_meas_engine #(
    parameter int NCHAN     = 8,
    parameter int NSAMP     = 8,
    parameter int ABITS     = 4,
    parameter int SQ_BITS   = 24,
    parameter int PR_BITS   = 21,
    parameter int WIN_LOG2  = 17,
    parameter int SQ_OFFSET = 16384
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       agc_tick_i,
    input  logic                       agc_ce_i,
    input  logic [NCHAN*ABITS-1:0]     abs_i,
    input  logic [NCHAN*NSAMP-1:0]     gt_i,
    input  logic [NCHAN*NSAMP-1:0]     lt_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       overrun_o,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic [$clog2(NCHAN)-1:0]   m_chan_o,
    output logic [SQ_BITS-1:0]         m_sq_o,
    output logic [PR_BITS-1:0]         m_gt_o,
    output logic [PR_BITS-1:0]         m_lt_o,
    output logic                       m_last_o,
    output logic [NCHAN-1:0]           sat_o
);
    localparam int CW = $clog2(NCHAN);
    localparam int PW = $clog2(NSAMP + 1);
    localparam int QW = 2 * ABITS;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    if (PR_BITS < WIN_LOG2 + PW) begin : g_pr_check
        $error("agc_meas_engine: PR_BITS too narrow for the window length");
    end

    state_t              state_q;
    logic                fl_q, done_q, ovr_q, v1_q, v2_q, mv_q, snap, last;
    logic [WIN_LOG2-1:0] cnt_q;
    logic [CW-1:0]       mc_q;
    logic [ABITS-1:0]    abs1_q [NCHAN];
    logic [NSAMP-1:0]    gt1_q [NCHAN];
    logic [NSAMP-1:0]    lt1_q [NCHAN];
    logic [QW-1:0]       sq1 [NCHAN];
    logic [QW-1:0]       sq2_q [NCHAN];
    logic [PW-1:0]       pg1 [NCHAN];
    logic [PW-1:0]       pl1 [NCHAN];
    logic [PW-1:0]       pg2_q [NCHAN];
    logic [PW-1:0]       pl2_q [NCHAN];
    logic [SQ_BITS-1:0]  acc_sq_q [NCHAN];
    logic [SQ_BITS-1:0]  acc_sq_d [NCHAN];
    logic [SQ_BITS-1:0]  h_sq_q [NCHAN];
    logic [PR_BITS-1:0]  acc_gt_q [NCHAN];
    logic [PR_BITS-1:0]  acc_gt_d [NCHAN];
    logic [PR_BITS-1:0]  acc_lt_q [NCHAN];
    logic [PR_BITS-1:0]  acc_lt_d [NCHAN];
    logic [PR_BITS-1:0]  h_gt_q [NCHAN];
    logic [PR_BITS-1:0]  h_lt_q [NCHAN];

    // A restart tick wins over the snapshot that would end the flush.
    assign snap = state_q == FLUSH && fl_q && !agc_tick_i;
    assign last = mc_q == CW'(NCHAN - 1);

    always_comb begin
        for (int c = 0; c < NCHAN; c++) begin
            sq1[c] = QW'(abs1_q[c]) * QW'(abs1_q[c]);
            pg1[c] = '0;
            pl1[c] = '0;
            for (int s = 0; s < NSAMP; s++) begin
                pg1[c] = pg1[c] + PW'(gt1_q[c][s]);
                pl1[c] = pl1[c] + PW'(lt1_q[c][s]);
            end
            acc_gt_d[c] = acc_gt_q[c] + (v2_q ? PR_BITS'(pg2_q[c]) : '0);
            acc_lt_d[c] = acc_lt_q[c] + (v2_q ? PR_BITS'(pl2_q[c]) : '0);
        end
    end

`ifdef AGC_MEAS_SAT_EN
    logic [SQ_BITS:0]   sq_sum [NCHAN];
    logic [NCHAN-1:0]   sat_q, sat_d;
    always_comb begin
        sat_d = sat_q;
        for (int c = 0; c < NCHAN; c++) begin
            sq_sum[c]   = {1'b0, acc_sq_q[c]} + (SQ_BITS + 1)'(sq2_q[c]);
            acc_sq_d[c] = !v2_q ? acc_sq_q[c] : sq_sum[c][SQ_BITS] ? '1 : sq_sum[c][SQ_BITS-1:0];
            sat_d[c]    = sat_q[c] | (v2_q & sq_sum[c][SQ_BITS]);
        end
    end
    always_ff @(posedge clk_i) sat_q <= (rst_i || agc_tick_i) ? '0 : sat_d;
    assign sat_o = sat_q;
`else
    always_comb begin
        for (int c = 0; c < NCHAN; c++)
            acc_sq_d[c] = acc_sq_q[c] + (v2_q ? SQ_BITS'(sq2_q[c]) : '0);
    end
    assign sat_o = '0;
`endif

    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NCHAN; c++) begin
            abs1_q[c] <= abs_i[ABITS*c +: ABITS];
            gt1_q[c]  <= gt_i[NSAMP*c +: NSAMP];
            lt1_q[c]  <= lt_i[NSAMP*c +: NSAMP];
            sq2_q[c]  <= sq1[c];
            pg2_q[c]  <= pg1[c];
            pl2_q[c]  <= pl1[c];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            fl_q    <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            mv_q    <= 1'b0;
            cnt_q   <= '0;
            mc_q    <= '0;
            for (int c = 0; c < NCHAN; c++) begin
                acc_sq_q[c] <= SQ_BITS'(SQ_OFFSET);
                acc_gt_q[c] <= '0;
                acc_lt_q[c] <= '0;
                h_sq_q[c]   <= '0;
                h_gt_q[c]   <= '0;
                h_lt_q[c]   <= '0;
            end
        end else begin
            done_q <= snap;
            // Samples in flight at a restart belong to the abandoned window.
            v1_q   <= agc_ce_i && state_q == RUN && !agc_tick_i;
            v2_q   <= v1_q && !agc_tick_i;
            for (int c = 0; c < NCHAN; c++) begin
                acc_sq_q[c] <= agc_tick_i ? SQ_BITS'(SQ_OFFSET) : acc_sq_d[c];
                acc_gt_q[c] <= agc_tick_i ? '0 : acc_gt_d[c];
                acc_lt_q[c] <= agc_tick_i ? '0 : acc_lt_d[c];
            end
            if (agc_tick_i) begin
                state_q <= RUN;
                cnt_q   <= '0;
                fl_q    <= 1'b0;
            end else if (state_q == RUN && agc_ce_i) begin
                cnt_q <= cnt_q + 1'b1;
                if (&cnt_q) state_q <= FLUSH;
            end else if (state_q == FLUSH) begin
                fl_q <= !fl_q;
                if (fl_q) state_q <= IDLE;
            end
            if (mv_q && m_ready_i) begin
                mv_q <= !last;
                mc_q <= last ? '0 : mc_q + 1'b1;
            end
            if (snap && mv_q) ovr_q <= 1'b1;
            // Snapshot takes the next-state sums so the final flushed sample is included.
            if (snap && !mv_q) begin
                mv_q <= 1'b1;
                mc_q <= '0;
                for (int c = 0; c < NCHAN; c++) begin
                    h_sq_q[c] <= acc_sq_d[c];
                    h_gt_q[c] <= acc_gt_d[c];
                    h_lt_q[c] <= acc_lt_d[c];
                end
            end
        end
    end

    assign busy_o    = state_q != IDLE;
    assign done_o    = done_q;
    assign overrun_o = ovr_q;
    assign m_valid_o = mv_q;
    assign m_chan_o  = mc_q;
    assign m_sq_o    = h_sq_q[mc_q];
    assign m_gt_o    = h_gt_q[mc_q];
    assign m_lt_o    = h_lt_q[mc_q];
    assign m_last_o  = mv_q && last;
endmodule

// File: tb/tb_agc_meas_engine.sv
// tb_agc_meas_engine: directed and randomized checks of agc_meas_engine against a window-level model.
module tb_agc_meas_engine;
    localparam int NCHAN = 2, WIN = 16, OFS = 16384;

    logic clk = 1'b0, rst = 1'b1, tick = 1'b0, ce = 1'b0, ready = 1'b0, ready_sat = 1'b1;
    logic [7:0]  abs_v = '0;
    logic [15:0] gt_v = '0, lt_v = '0;
    logic        busy, done, ovr, mv, mlast;
    logic [0:0]  mch;
    logic [23:0] msq;
    logic [20:0] mgt, mlt;
    logic [1:0]  sat;
    logic        s_busy, s_done, s_ovr, s_mv, s_last;
    logic [0:0]  s_mch;
    logic [14:0] s_msq;
    logic [20:0] s_mgt, s_mlt;
    logic [1:0]  s_sat;
    int checks = 0, errors = 0, done_cnt = 0;

    always #5 clk = ~clk;

    agc_meas_engine #(.NCHAN(2), .NSAMP(8), .ABITS(4), .SQ_BITS(24), .PR_BITS(21),
                      .WIN_LOG2(4), .SQ_OFFSET(OFS)) u_dut (
        .clk_i(clk), .rst_i(rst), .agc_tick_i(tick), .agc_ce_i(ce), .abs_i(abs_v),
        .gt_i(gt_v), .lt_i(lt_v), .busy_o(busy), .done_o(done), .overrun_o(ovr),
        .m_valid_o(mv), .m_ready_i(ready), .m_chan_o(mch), .m_sq_o(msq), .m_gt_o(mgt),
        .m_lt_o(mlt), .m_last_o(mlast), .sat_o(sat));

    agc_meas_engine #(.NCHAN(2), .NSAMP(8), .ABITS(4), .SQ_BITS(15), .PR_BITS(21),
                      .WIN_LOG2(4), .SQ_OFFSET(32000)) u_sat (
        .clk_i(clk), .rst_i(rst), .agc_tick_i(tick), .agc_ce_i(ce), .abs_i(abs_v),
        .gt_i(gt_v), .lt_i(lt_v), .busy_o(s_busy), .done_o(s_done), .overrun_o(s_ovr),
        .m_valid_o(s_mv), .m_ready_i(ready_sat), .m_chan_o(s_mch), .m_sq_o(s_msq), .m_gt_o(s_mgt),
        .m_lt_o(s_mlt), .m_last_o(s_last), .sat_o(s_sat));

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Window-level model: samples are summed the moment they qualify; no pipeline.
    int     e_ph = 0, e_cnt = 0, e_fl = 0, e_ch = 0;
    bit     e_done = 0, e_ovr = 0, e_mv = 0, snap = 0, pend = 0;
    longint e_sq[2], e_gt[2], e_lt[2], h_sq[2], h_gt[2], h_lt[2];

    always @(posedge clk) begin
        if (rst) begin
            e_ph = 0; e_cnt = 0; e_fl = 0; e_ch = 0; e_done = 0; e_ovr = 0; e_mv = 0;
            for (int c = 0; c < NCHAN; c++) begin
                e_sq[c] = OFS; e_gt[c] = 0; e_lt[c] = 0; h_sq[c] = 0; h_gt[c] = 0; h_lt[c] = 0;
            end
        end else begin
            snap = 0; e_done = 0; pend = e_mv;
            if (tick) begin
                e_ph = 1; e_cnt = 0;
                for (int c = 0; c < NCHAN; c++) begin e_sq[c] = OFS; e_gt[c] = 0; e_lt[c] = 0; end
            end else if (e_ph == 1 && ce) begin
                for (int c = 0; c < NCHAN; c++) begin
                    e_sq[c] += (abs_v >> (4 * c)) % 16 * ((abs_v >> (4 * c)) % 16);
                    e_gt[c] += $countones(gt_v[8*c +: 8]);
                    e_lt[c] += $countones(lt_v[8*c +: 8]);
                end
                e_cnt++;
                if (e_cnt == WIN) begin e_ph = 2; e_fl = 2; end
            end else if (e_ph == 2) begin
                e_fl--;
                if (e_fl == 0) begin snap = 1; e_ph = 0; end
            end
            if (e_mv && ready) begin
                if (e_ch == NCHAN - 1) begin e_mv = 0; e_ch = 0; end else e_ch++;
            end
            if (snap) begin
                e_done = 1;
                if (pend) e_ovr = 1;
                else begin
                    e_mv = 1; e_ch = 0;
                    for (int c = 0; c < NCHAN; c++) begin h_sq[c] = e_sq[c]; h_gt[c] = e_gt[c]; h_lt[c] = e_lt[c]; end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, e_ph != 0);
        chk("done", done, e_done);
        chk("overrun", ovr, e_ovr);
        chk("m_valid", mv, e_mv);
        chk("m_last", mlast, e_mv && e_ch == NCHAN - 1);
        chk("sat", sat, 0);
        if (e_mv) begin
            chk("m_chan", mch, e_ch);
            chk("m_sq", msq, h_sq[e_ch]);
            chk("m_gt", mgt, h_gt[e_ch]);
            chk("m_lt", mlt, h_lt[e_ch]);
        end
        if (done) done_cnt++;
    end

    task automatic set_pat(input logic [3:0] a0, a1, input logic [7:0] g0, g1, l0, l1);
        abs_v = {a1, a0}; gt_v = {g1, g0}; lt_v = {l1, l0};
    endtask

    task automatic run_window(input bit alt, output int n);
        tick = 1'b1; ce = 1'b1; n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            n++;
            tick = 1'b0;
            if (alt) ce = n % 2 == 0;
            if (done) break;
        end
        ce = 1'b1;
    endtask

    task automatic get_beats(output longint sq[2], gt[2], lt[2], output int lastch);
        for (int c = 0; c < NCHAN; c++) begin sq[c] = -1; gt[c] = -1; lt[c] = -1; end
        lastch = -1;
        ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (mv) begin
                sq[mch] = msq; gt[mch] = mgt; lt[mch] = mlt;
                if (mlast) lastch = mch;
            end
            @(negedge clk);
            if (lastch >= 0) break;
        end
        ready = 1'b0;
    endtask

    task automatic chk_a(input string tag, input longint sq[2], gt[2], lt[2], input int lastch);
        chk({tag, "_sq0"}, sq[0], 16640); chk({tag, "_gt0"}, gt[0], 128); chk({tag, "_lt0"}, lt[0], 0);
        chk({tag, "_sq1"}, sq[1], 16384); chk({tag, "_gt1"}, gt[1], 0);   chk({tag, "_lt1"}, lt[1], 64);
        chk({tag, "_lastch"}, lastch, 1);
    endtask

    initial begin
        longint sq[2], gt[2], lt[2];
        int n, lastch, d0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0); chk("rst_valid", mv, 0); chk("rst_overrun", ovr, 0);
        chk("rst_last", mlast, 0); chk("rst_chan", mch, 0); chk("rst_sat", s_sat, 0);
        rst = 1'b0;
        @(negedge clk);

        set_pat(4, 0, 8'hFF, 8'h00, 8'h00, 8'h0F);
        run_window(0, n);
        chk("basic_done_latency", n, 19);
        get_beats(sq, gt, lt, lastch);
        chk_a("basic", sq, gt, lt, lastch);

        run_window(1, n);
        chk("alt_done_latency", n, 35);
        get_beats(sq, gt, lt, lastch);
        chk_a("alt", sq, gt, lt, lastch);

        d0 = done_cnt;
        tick = 1'b1; ce = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (7) @(negedge clk);
        set_pat(2, 0, 8'hFF, 8'h00, 8'h00, 8'h0F);
        run_window(0, n);
        chk("restart_latency", n, 19);
        repeat (3) @(negedge clk);
        chk("restart_done_count", done_cnt - d0, 1);
        get_beats(sq, gt, lt, lastch);
        chk("restart_sq0", sq[0], 16448);
        chk("restart_gt0", gt[0], 128);

        set_pat(4, 0, 8'hFF, 8'h00, 8'h00, 8'h0F);
        run_window(0, n);
        set_pat(3, 5, 8'h0F, 8'h01, 8'h03, 8'h77);
        run_window(0, n);
        chk("overrun_latency", n, 19);
        @(negedge clk);
        chk("overrun_set", ovr, 1);
        get_beats(sq, gt, lt, lastch);
        chk_a("overrun", sq, gt, lt, lastch);

        set_pat(4, 0, 8'hFF, 8'h00, 8'h00, 8'h0F);
        run_window(0, n);
        chk("sticky_overrun", ovr, 1);
        ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_chan", mch, 1);
        rst = 1'b1; ready = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", mv, 0);
        chk("rst_mid_overrun", ovr, 0);
        rst = 1'b0; ready = 1'b1; n = 0;
        repeat (5) begin @(negedge clk); n += mv; end
        chk("rst_mid_no_beat", n, 0);
        ready = 1'b0;

        set_pat(15, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        run_window(0, n);
        chk("sat_chan", s_mch, 0);
`ifdef AGC_MEAS_SAT_EN
        chk("sat_sq0", s_msq, 32767);
        chk("sat_flag0", s_sat[0], 1);
`else
        chk("wrap_sq0", s_msq, 2832);
        chk("wrap_flag0", s_sat, 0);
`endif
        get_beats(sq, gt, lt, lastch);

        for (int k = 0; k < 4000; k++) begin
            abs_v = 8'($urandom); gt_v = 16'($urandom); lt_v = 16'($urandom);
            ce    = $urandom_range(3) != 0;
            ready = $urandom_range(2) != 0;
            tick  = $urandom_range(49) == 0;
            rst   = $urandom_range(899) == 0;
            @(negedge clk);
        end
        rst = 1'b0; tick = 1'b0;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
